// File: rtl/comparator_pkg.sv
// Shared result encoding for the registered magnitude comparator.
// Flags are one-hot {gt, eq, lt}; all-zero means no result yet.
package comparator_pkg;

  typedef logic [2:0] cmp_result_t;

  localparam cmp_result_t CMP_GT   = 3'b100;
  localparam cmp_result_t CMP_EQ   = 3'b010;
  localparam cmp_result_t CMP_LT   = 3'b001;
  localparam cmp_result_t CMP_NONE = 3'b000;

  localparam int CMP_GT_BIT = 2;
  localparam int CMP_EQ_BIT = 1;
  localparam int CMP_LT_BIT = 0;

endpackage

// File: rtl/comparator_core.sv
// Combinational MSB-first compare cascade, WIDTH-generic.
// The first differing bit decides; in signed mode the MSB decision flips.
module comparator_core
  import comparator_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter bit SIGNED = 1'b0
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output cmp_result_t      o_res
);

  logic w_found;

  always_comb begin
    o_res   = CMP_EQ;
    w_found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!w_found && (i_a[i] != i_b[i])) begin
        w_found = 1'b1;
        // A set sign bit marks the smaller operand
        if (SIGNED && (i == WIDTH - 1))
          o_res = i_a[i] ? CMP_LT : CMP_GT;
        else
          o_res = i_a[i] ? CMP_GT : CMP_LT;
      end
    end
  end

endmodule

// File: rtl/comparator_4b_behavioral.sv
// Registered magnitude comparator with a one-cycle valid pipeline.
// Flags hold their last result while in_valid is low.
module comparator_4b_behavioral
  import comparator_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic             A_great_B,
  output logic             A_equal_B,
  output logic             A_less_B
);

  cmp_result_t w_res;
  cmp_result_t r_res;
  logic        r_valid;

  comparator_core #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED)
  ) u_core (
    .i_a   (A),
    .i_b   (B),
    .o_res (w_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_res   <= CMP_NONE;
    end else begin
      r_valid <= in_valid;
      if (in_valid)
        r_res <= w_res;
    end
  end

  assign out_valid = r_valid;
  assign A_great_B = r_res[CMP_GT_BIT];
  assign A_equal_B = r_res[CMP_EQ_BIT];
  assign A_less_B  = r_res[CMP_LT_BIT];

endmodule

// File: tb/tb_comparator_4b_behavioral.sv
// Bench for the registered comparator: unsigned and signed
// instances share stimulus; expectations come from integer compares.
module tb_comparator_4b_behavioral;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] A;
  logic [3:0] B;

  logic u_ov, u_gt, u_eq, u_lt;
  logic s_ov, s_gt, s_eq, s_lt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  comparator_4b_behavioral #(.WIDTH(4), .SIGNED(1'b0)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .out_valid (u_ov),
    .A_great_B (u_gt),
    .A_equal_B (u_eq),
    .A_less_B  (u_lt)
  );

  comparator_4b_behavioral #(.WIDTH(4), .SIGNED(1'b1)) s_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .out_valid (s_ov),
    .A_great_B (s_gt),
    .A_equal_B (s_eq),
    .A_less_B  (s_lt)
  );

  function automatic logic [2:0] ref_cmp(input int a, input int b);
    return {a > b, a == b, a < b};
  endfunction

  function automatic int sval(input logic [3:0] x);
    int v;
    v = int'(x);
    if (v >= 8) v = v - 16;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; A = 4'b0101; B = 4'b0000;
    tick(); tick();
    checks++;
    if ({u_ov, u_gt, u_eq, u_lt} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_u got=%b exp=0000", {u_ov, u_gt, u_eq, u_lt});
    end
    checks++;
    if ({s_ov, s_gt, s_eq, s_lt} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_s got=%b exp=0000", {s_ov, s_gt, s_eq, s_lt});
    end
    rst_n = 1'b1;
    A = 4'b0011; B = 4'b0001;
    tick();
    checks++;
    if ({u_ov, u_gt, u_eq, u_lt} !== 4'b1100) begin
      failures++;
      $display("FAIL pre_async got=%b exp=1100", {u_ov, u_gt, u_eq, u_lt});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({u_ov, u_gt, u_eq, u_lt} !== 4'b0000) begin
      failures++;
      $display("FAIL async_clear got=%b exp=0000", {u_ov, u_gt, u_eq, u_lt});
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({u_ov, u_gt, u_eq, u_lt} !== 4'b1100) begin
      failures++;
      $display("FAIL post_release got=%b exp=1100", {u_ov, u_gt, u_eq, u_lt});
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_unsigned_sweep();
    logic [3:0] ta [7] = '{4'b0000, 4'b1110, 4'b0011, 4'b1111,
                           4'b0000, 4'b1111, 4'b0101};
    logic [3:0] tb [7] = '{4'b0000, 4'b1101, 4'b0011, 4'b0000,
                           4'b1111, 4'b1111, 4'b1010};
    logic [2:0] te [7] = '{3'b010, 3'b100, 3'b010, 3'b100,
                           3'b001, 3'b010, 3'b001};
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; A = ta[i]; B = tb[i];
      tick();
      checks++;
      if ({u_ov, u_gt, u_eq, u_lt} !== {1'b1, te[i]}) begin
        failures++;
        $display("FAIL usweep[%0d] got=%b exp=%b", i,
                 {u_ov, u_gt, u_eq, u_lt}, {1'b1, te[i]});
      end
    end
  endtask

  task automatic test_hold();
    in_valid = 1'b0; A = 4'b1111;
    tick();
    checks++;
    if ({u_ov, u_gt, u_eq, u_lt} !== 4'b0001) begin
      failures++;
      $display("FAIL hold got=%b exp=0001", {u_ov, u_gt, u_eq, u_lt});
    end
    A = 4'bxxxx; B = 4'bzzzz;
    tick();
    checks++;
    if ({u_ov, u_gt, u_eq, u_lt} !== 4'b0001) begin
      failures++;
      $display("FAIL hold_x got=%b exp=0001", {u_ov, u_gt, u_eq, u_lt});
    end
  endtask

  task automatic test_signed();
    logic [3:0] ta [4] = '{4'b1000, 4'b1111, 4'b0001, 4'b1010};
    logic [3:0] tb [4] = '{4'b0111, 4'b0000, 4'b1111, 4'b1010};
    logic [2:0] te [4] = '{3'b001, 3'b001, 3'b100, 3'b010};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; A = ta[i]; B = tb[i];
      tick();
      checks++;
      if ({s_ov, s_gt, s_eq, s_lt} !== {1'b1, te[i]}) begin
        failures++;
        $display("FAIL ssweep[%0d] got=%b exp=%b", i,
                 {s_ov, s_gt, s_eq, s_lt}, {1'b1, te[i]});
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_exhaustive();
    logic [2:0] exp_u;
    logic [2:0] exp_s;
    int gaps;
    exp_u = 3'b000;
    exp_s = 3'b000;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        gaps = (a == 0 && b == 0) ? 0 : int'($urandom_range(0, 2));
        for (int g = 0; g < gaps; g++) begin
          in_valid = 1'b0;
          A = 4'($urandom); B = 4'($urandom);
          tick();
          checks++;
          if ({u_ov, u_gt, u_eq, u_lt} !== {1'b0, exp_u}) begin
            failures++;
            $display("FAIL gap_u a=%0d b=%0d got=%b exp=%b", a, b,
                     {u_ov, u_gt, u_eq, u_lt}, {1'b0, exp_u});
          end
          checks++;
          if ({s_ov, s_gt, s_eq, s_lt} !== {1'b0, exp_s}) begin
            failures++;
            $display("FAIL gap_s a=%0d b=%0d got=%b exp=%b", a, b,
                     {s_ov, s_gt, s_eq, s_lt}, {1'b0, exp_s});
          end
        end
        in_valid = 1'b1; A = 4'(a); B = 4'(b);
        exp_u = ref_cmp(a, b);
        exp_s = ref_cmp(sval(4'(a)), sval(4'(b)));
        tick();
        checks++;
        if ({u_ov, u_gt, u_eq, u_lt} !== {1'b1, exp_u}) begin
          failures++;
          $display("FAIL rnd_u a=%0d b=%0d got=%b exp=%b", a, b,
                   {u_ov, u_gt, u_eq, u_lt}, {1'b1, exp_u});
        end
        checks++;
        if ({s_ov, s_gt, s_eq, s_lt} !== {1'b1, exp_s}) begin
          failures++;
          $display("FAIL rnd_s a=%0d b=%0d got=%b exp=%b", a, b,
                   {s_ov, s_gt, s_eq, s_lt}, {1'b1, exp_s});
        end
        checks++;
        if ($countones({s_gt, s_eq, s_lt}) != 1 ||
            $countones({u_gt, u_eq, u_lt}) != 1) begin
          failures++;
          $display("FAIL onehot a=%0d b=%0d u=%b s=%b exp=one-hot", a, b,
                   {u_gt, u_eq, u_lt}, {s_gt, s_eq, s_lt});
        end
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time=%0t exp=finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_unsigned_sweep();
    test_hold();
    test_signed();
    test_exhaustive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/comparator_4b_behavioral.md
Name: comparator_4b_behavioral

Overview:
- Registered magnitude comparator: compares two WIDTH-bit operands A and B and reports exactly one of greater / equal / less.
- Sits in datapath control logic wherever an operand ordering decision is needed.
- Default is 4-bit unsigned.
- Results are registered, with a one-cycle valid pipeline.

Parameters:
- WIDTH, 4, operand width in bits (legal range 1..32).
- SIGNED, 0, 0 = unsigned compare; 1 = two's-complement compare.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  A/B are valid this cycle; sample them.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- out_valid  output  1  result flags reflect the last sampled A/B.
- A_great_B  output  1  A > B.
- A_equal_B  output  1  A == B.
- A_less_B  output  1  A < B.

Behaviour:
- One clock, single domain. Reset is asynchronous and active-low: rst_n low forces state immediately, with no clock needed. Deassertion is synchronous to clk externally.
- Reset values: out_valid=0, A_great_B=0, A_equal_B=0, A_less_B=0.
- Latency: exactly 1 cycle.
  - If in_valid=1 at rising edge N, the flags for that A/B appear after edge N, and out_valid=1 for cycle N+1.
- If in_valid=0 at an edge:
  - out_valid goes 0.
  - Flags hold their previous values (no glitching, no clearing).
- Back-to-back: in_valid high every cycle gives one result per cycle (full throughput). No backpressure; no ready signal.
- Flag invariant: whenever out_valid=1, exactly one of the three flags is 1 (one-hot).
- Compare rules:
  - SIGNED=0: operands are unsigned 0..2^WIDTH-1.
  - SIGNED=1: MSB is the sign bit. Example for WIDTH=4: 4'b1000 (-8) < 4'b0111 (+7).
- Compare algorithm: MSB-first cascade.
  - The first differing bit position decides; the higher operand has 1 at that bit.
  - In signed mode, the decision at the MSB is inverted.
  - If no bit differs, the result is equal.
- Width boundaries: all-zeros vs all-ones gives less (unsigned) or greater (signed, since 0 > -1). Equal operands at any value give equal.
- X/Z on A/B while in_valid=0: ignored, no effect on state.
- Reset mid-operation: rst_n low while in_valid high drops out_valid and clears all flags immediately. The in-flight sample is discarded. The first edge after release with in_valid=1 starts a fresh result.

Decomposition:
- Shared package comparator_pkg:
  - Result encoding constants, a 3-bit one-hot: CMP_GT=3'b100, CMP_EQ=3'b010, CMP_LT=3'b001, CMP_NONE=3'b000.
  - A cmp_result_t typedef, used internally.
- Output flags are the bits of the registered cmp_result_t.
- One natural sub-module: comparator_core, the purely combinational WIDTH-generic cascade.
  - Inputs: A, B, SIGNED.
  - Output: cmp_result_t.
  - The top wraps it with the valid/result registers.

Test Plan:
1. Reset: hold rst_n=0 with in_valid=1, A=4'b0101, B=4'b0000 -> out_valid=0, all flags 0. Assert rst_n=0 mid-run and check the async clear without a clock edge.
2. Unsigned sweep, one per cycle, using SIGNED=0, WIDTH=4 and in_valid=1. Each result appears 1 cycle later, and out_valid stays high throughout.
   - (0000,0000) -> EQ.
   - (1110,1101) -> GT.
   - (0011,0011) -> EQ.
   - (0101,1010) -> LT.
3. Hold behaviour: after the (0101,1010) result, drop in_valid and change A=1111 -> out_valid=0, A_less_B stays 1, other flags 0.
4. Boundaries, unsigned: (1111,0000) -> GT; (0000,1111) -> LT; (1111,1111) -> EQ.
5. Signed instance, SIGNED=1: (1000,0111) -> LT; (1111,0000) -> LT; (0001,1111) -> GT; (1010,1010) -> EQ.
6. Exhaustive random: all 256 A/B pairs for WIDTH=4, both SIGNED values, with random in_valid gaps. Checks:
   - Flags match a reference model of a > b, a == b, a < b.
   - Flags are one-hot whenever out_valid=1.
   - Latency is exactly 1.
